// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/ack fetch, IF/ID register, one-entry stall hold buffer, redirect discard.
// Optional build macro FETCH_CNT_EN adds the fetch_cnt / drop_cnt statistics outputs.
module fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [15:0]     if_imm,
`ifdef FETCH_CNT_EN
    output logic [31:0]     fetch_cnt,
    output logic [15:0]     drop_cnt,
`endif
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] hold_instr;
    logic [XLEN-1:0] hold_pc;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] redir_tgt;
    logic            consumed;

    // Handshake: imem_req is a level held with a stable imem_addr until a one-cycle imem_ack
    // returns imem_rdata; the IF/ID entry is taken by decode on any cycle with if_valid && !stall.
    assign imem_req  = (state == FETCH) || (state == DROP);
    assign imem_addr = addr_q;
    assign if_imm    = if_instr[15:0];
    assign state_dbg = state;

    assign pc_inc    = pc + STEP;
    assign redir_tgt = redirect_pc & ~(XLEN'(3));
    assign consumed  = !if_valid || !stall;

    // Being in HOLD is what marks the hold buffer as occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            addr_q     <= '0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
            pc       <= redir_tgt;
            // A request still outstanding must see its ack before refetching.
            if (!imem_ack && (state == FETCH || state == DROP)) begin
                state <= DROP;
            end else begin
                state  <= FETCH;
                addr_q <= redir_tgt;
            end
        end else begin
            case (state)
                IDLE: begin
                    state  <= FETCH;
                    addr_q <= pc;
                end
                FETCH: begin
                    if (imem_ack) begin
                        pc <= pc_inc;
                        if (consumed) begin
                            if_instr <= imem_rdata;
                            if_pc    <= addr_q;
                            if_valid <= 1'b1;
                            addr_q   <= pc_inc;
                        end else begin
                            hold_instr <= imem_rdata;
                            hold_pc    <= addr_q;
                            state      <= HOLD;
                        end
                    end else if (if_valid && !stall) begin
                        if_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_instr <= hold_instr;
                        if_pc    <= hold_pc;
                        if_valid <= 1'b1;
                        addr_q   <= pc;
                        state    <= FETCH;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        addr_q <= pc;
                        state  <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_CNT_EN
    logic load_evt;
    logic drop_evt;

    assign load_evt = !redirect_valid &&
                      ((state == FETCH && imem_ack && consumed) || (state == HOLD && !stall));
    assign drop_evt = imem_ack && ((state == FETCH && redirect_valid) || state == DROP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (load_evt && fetch_cnt != '1) fetch_cnt <= fetch_cnt + 32'd1;
            if (drop_evt && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed handshake/stall/redirect/wrap/reset cases plus random gaps.
// Build with +define+FETCH_CNT_EN to also check the statistics counters.
module tb_fetch_stage;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [15:0] if_imm;
    logic [1:0]  state_dbg;
`ifdef FETCH_CNT_EN
    logic [31:0] fetch_cnt;
    logic [15:0] drop_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] next_addr;
    int          n_kept = 0;
    int          n_drop = 0;

    fetch_stage #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_imm        (if_imm),
`ifdef FETCH_CNT_EN
        .fetch_cnt     (fetch_cnt),
        .drop_cnt      (drop_cnt),
`endif
        .state_dbg     (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // scoreboard: pop one expected {pc, instr} each time decode takes the IF/ID entry
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n && if_valid && !stall && !redirect_valid) begin
            check("sb_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_entry", {if_pc, if_instr}, e);
                check("sb_imm", 64'(if_imm), 64'(e[15:0]));
            end
        end
    end

    // drive one cycle of inputs (called at posedge+1), return at the next posedge+1
    task automatic step(input logic ack, input logic [31:0] rdata, input logic stl,
                        input logic rv, input logic [31:0] rpc);
        imem_ack       = ack;
        imem_rdata     = rdata;
        stall          = stl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rv) exp_q.delete();
        @(posedge clk);
        #1;
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
    endtask

    // acknowledge the pending request with data that is expected to reach decode
    task automatic ack_keep(input logic [31:0] rdata, input logic stl);
        check("req_at_ack", 64'(imem_req), 64'd1);
        check("addr_at_ack", 64'(imem_addr), 64'(next_addr));
        exp_q.push_back({next_addr, rdata});
        n_kept++;
        next_addr = next_addr + 32'd4;
        step(1'b1, rdata, stl, 1'b0, 32'h0);
    endtask

    initial begin
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(if_valid), 64'd0);
        check("rst_instr", 64'(if_instr), 64'd0);
        check("rst_pc", 64'(if_pc), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(S_IDLE));
`ifdef FETCH_CNT_EN
        check("rst_fcnt", 64'(fetch_cnt), 64'd0);
        check("rst_dcnt", 64'(drop_cnt), 64'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_state", 64'(state_dbg), 64'(S_FETCH));
        next_addr = 32'h0;

        // back-to-back acks, no stall
        for (int i = 0; i < 4; i++) begin
            ack_keep(32'h1000_0000 + 32'(i), 1'b0);
            if (i == 0) begin
                check("lat_valid", 64'(if_valid), 64'd1);
                check("lat_pc", 64'(if_pc), 64'd0);
            end
        end

        // ack while decode stalls a live entry -> hold buffer
        ack_keep(32'h2001_8005, 1'b1);
        check("hold_state", 64'(state_dbg), 64'(S_HOLD));
        check("hold_req", 64'(imem_req), 64'd0);
        repeat (3) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            check("hold_frozen", 64'(state_dbg), 64'(S_HOLD));
            check("hold_req_low", 64'(imem_req), 64'd0);
            check("hold_if_pc", 64'(if_pc), 64'h0000_000C);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("rel_instr", 64'(if_instr), 64'h2001_8005);
        check("rel_imm", 64'(if_imm), 64'h8005);
        check("rel_pc", 64'(if_pc), 64'h0000_0010);
        check("rel_addr", 64'(imem_addr), 64'h0000_0014);
        ack_keep(32'h3000_0014, 1'b0);

        // redirect with a request pending, late ack discarded
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
        check("drop_state", 64'(state_dbg), 64'(S_DROP));
        check("drop_req", 64'(imem_req), 64'd1);
        check("drop_addr", 64'(imem_addr), 64'h0000_0018);
        check("drop_valid", 64'(if_valid), 64'd0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        n_drop++;
        check("late_valid", 64'(if_valid), 64'd0);
        check("late_state", 64'(state_dbg), 64'(S_FETCH));
        check("redir_addr", 64'(imem_addr), 64'h0000_0100);
        next_addr = 32'h0000_0100;

        // redirect and ack together while stalled
        ack_keep(32'h4000_0100, 1'b0);
        step(1'b1, 32'hBAD0_0001, 1'b1, 1'b1, 32'h0000_0200);
        n_drop++;
        check("same_valid", 64'(if_valid), 64'd0);
        check("same_state", 64'(state_dbg), 64'(S_FETCH));
        check("same_addr", 64'(imem_addr), 64'h0000_0200);
        next_addr = 32'h0000_0200;

        // second redirect in DROP only moves pc; then wrap at the top of memory
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0300);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        check("drop2_state", 64'(state_dbg), 64'(S_DROP));
        check("drop2_addr", 64'(imem_addr), 64'h0000_0200);
        step(1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
        n_drop++;
        check("top_addr", 64'(imem_addr), 64'hFFFF_FFFC);
        next_addr = 32'hFFFF_FFFC;
        ack_keep(32'h6000_0000, 1'b0);
        check("wrap_addr", 64'(imem_addr), 64'h0000_0000);

        // random ack gaps with random stall
        for (int i = 0; i < 24; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step(1'b0, $urandom, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
            ack_keep($urandom, 1'b0);
        end
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
`ifdef FETCH_CNT_EN
        check("fetch_cnt", 64'(fetch_cnt), 64'(n_kept));
        check("drop_cnt", 64'(drop_cnt), 64'(n_drop));
`endif

        // asynchronous reset in the middle of a request
        ack_keep(32'h7000_0000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", 64'(imem_req), 64'd0);
        check("arst_valid", 64'(if_valid), 64'd0);
        check("arst_state", 64'(state_dbg), 64'(S_IDLE));
`ifdef FETCH_CNT_EN
        check("arst_fcnt", 64'(fetch_cnt), 64'd0);
        check("arst_dcnt", 64'(drop_cnt), 64'd0);
`endif
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hACED_0000;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        check("idle_ack_state", 64'(state_dbg), 64'(S_FETCH));
        check("idle_ack_valid", 64'(if_valid), 64'd0);
        check("restart_addr", 64'(imem_addr), 64'h0000_0000);
        next_addr = 32'h0;
        ack_keep(32'h8000_0000, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("sb_final", 64'(exp_q.size()), 64'd0);
`ifdef FETCH_CNT_EN
        check("post_fcnt", 64'(fetch_cnt), 64'd1);
        check("post_dcnt", 64'(drop_cnt), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
